// File: rtl/sst_flash_sequencer_if.sv
// Bundle of PI window, command port and SST flash pin signals.
// The slave modport is the sequencer; the master modport is the PI/command client plus the flash.
interface sst_flash_sequencer_if #(
   parameter int ADDR_W = 19
);
   logic              pi_req;
   logic [ADDR_W-1:0] pi_addr;
   logic              pi_ce_n;
   logic              pi_oe_n;
   logic              pi_we_n;
   logic              pi_gnt;
   logic              cmd_start;
   logic [2:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        cmd_data;
   logic              cmd_busy;
   logic              cmd_done;
   logic              cmd_err;
   logic [ADDR_W-1:0] sst_addr;
   logic              sst_ce_n;
   logic              sst_oe_n;
   logic              sst_we_n;
   logic [7:0]        sst_dq_o;
   logic              sst_dq_oe;
   logic [7:0]        sst_dq_i;

   modport slave (
      input  pi_req, pi_addr, pi_ce_n, pi_oe_n, pi_we_n,
      input  cmd_start, cmd_op, cmd_addr, cmd_data,
      input  sst_dq_i,
      output pi_gnt, cmd_busy, cmd_done, cmd_err,
      output sst_addr, sst_ce_n, sst_oe_n, sst_we_n, sst_dq_o, sst_dq_oe
   );

   modport master (
      output pi_req, pi_addr, pi_ce_n, pi_oe_n, pi_we_n,
      output cmd_start, cmd_op, cmd_addr, cmd_data,
      output sst_dq_i,
      input  pi_gnt, cmd_busy, cmd_done, cmd_err,
      input  sst_addr, sst_ce_n, sst_oe_n, sst_we_n, sst_dq_o, sst_dq_oe
   );
endinterface

// File: rtl/sst_flash_sequencer.sv
// SST flash pin owner: arbitrates PI window accesses against JEDEC command sequences
// and tracks program/erase completion with DQ7 data# polling and a poll-count timeout.
//
// state    | meaning
// IDLE     | pins parked, waiting for pi_req or a pending command
// PI       | pins follow pi_* with one clock of latency
// SETUP    | CE# low, address/data driven, WE# still high
// WPULSE   | WE# low
// HOLD     | WE#/CE# high, data still driven; step advances here
// POLL_RD  | CE#/OE# low at cmd_addr, DQ7 captured on the last clock
// POLL_GAP | strobes high, poll result evaluated
// DONE     | cmd_done pulse
module sst_flash_sequencer #(
   parameter int ADDR_W    = 19,
   parameter int T_SU      = 2,
   parameter int T_WP      = 4,
   parameter int T_RD      = 3,
   parameter int TMO_PROG  = 2048,
   parameter int TMO_ERASE = 2097151
) (
   input logic                  clk,
   input logic                  cold_reset,
   sst_flash_sequencer_if.slave bus
);
   localparam int CNT_W = 8;
   localparam logic [2:0] OP_PROG = 3'd0;
   localparam logic [2:0] OP_SER  = 3'd1;
   localparam logic [2:0] OP_CER  = 3'd2;
   localparam logic [2:0] OP_IDEN = 3'd3;
   localparam logic [2:0] OP_IDEX = 3'd4;
   localparam logic [ADDR_W-1:0] C_5555 = ADDR_W'(15'h5555);
   localparam logic [ADDR_W-1:0] C_2AAA = ADDR_W'(15'h2AAA);
   localparam logic [20:0] TMO_P = 21'(TMO_PROG);
   localparam logic [20:0] TMO_E = 21'(TMO_ERASE);

   typedef enum logic [2:0] {
      S_IDLE, S_PI, S_SETUP, S_WPULSE, S_HOLD, S_POLL_RD, S_POLL_GAP, S_DONE
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_step, w_step_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [20:0]       r_poll, w_poll_nxt;
   logic              r_dq7, w_dq7_nxt;
   logic              w_tmo_err;
   logic              r_pending, r_bad, r_busy, r_done, r_err;
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_data;
   logic [ADDR_W-1:0] r_sst_addr, w_addr;
   logic [7:0]        r_dq_o, w_dq_o;
   logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_gnt;
   logic              w_ce_n, w_oe_n, w_we_n, w_dq_oe, w_gnt;
   logic [ADDR_W+7:0] w_word;
   logic              w_accept, w_bad_op, w_enter_done, w_polled, w_pass_val;
   logic [2:0]        w_last;
   logic [20:0]       w_tmo;

   function automatic logic [ADDR_W+7:0] seq_word(input logic [2:0] op, input logic [2:0] step,
                                                  input logic [ADDR_W-1:0] a, input logic [7:0] d);
      logic [ADDR_W+7:0] w;
      w = {C_5555, 8'hAA};
      if (op == OP_IDEX) begin
         w = {C_5555, 8'hF0};
      end else begin
         case (step)
            3'd0:    w = {C_5555, 8'hAA};
            3'd1:    w = {C_2AAA, 8'h55};
            3'd2:    w = (op == OP_PROG) ? {C_5555, 8'hA0} :
                         (op == OP_IDEN) ? {C_5555, 8'h90} : {C_5555, 8'h80};
            3'd3:    w = (op == OP_PROG) ? {a, d} : {C_5555, 8'hAA};
            3'd4:    w = {C_2AAA, 8'h55};
            default: w = (op == OP_SER) ? {a, 8'h30} : {C_5555, 8'h10};
         endcase
      end
      return w;
   endfunction

   assign w_accept     = bus.cmd_start && !r_busy;
   assign w_bad_op     = (bus.cmd_op > OP_IDEX);
   assign w_polled     = (r_op == OP_PROG) || (r_op == OP_SER) || (r_op == OP_CER);
   assign w_pass_val   = (r_op == OP_PROG) ? r_data[7] : 1'b1;
   assign w_tmo        = (r_op == OP_PROG) ? TMO_P : TMO_E;
   assign w_last       = (r_op == OP_PROG) ? 3'd3 :
                         (r_op == OP_IDEN) ? 3'd2 :
                         (r_op == OP_IDEX) ? 3'd0 : 3'd5;
   assign w_enter_done = (w_state_nxt == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_cnt_nxt   = r_cnt;
      w_poll_nxt  = r_poll;
      w_dq7_nxt   = r_dq7;
      w_tmo_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // PI has priority; a pending command waits for pi_req to drop
            if (bus.pi_req) begin
               w_state_nxt = S_PI;
            end else if (r_pending) begin
               w_state_nxt = S_SETUP;
               w_step_nxt  = 3'd0;
               w_cnt_nxt   = CNT_W'(T_SU - 1);
               w_poll_nxt  = '0;
            end
         end
         S_PI: if (!bus.pi_req) w_state_nxt = S_IDLE;
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_WPULSE;
               w_cnt_nxt   = CNT_W'(T_WP - 1);
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_WPULSE: begin
            if (r_cnt == '0) w_state_nxt = S_HOLD;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         S_HOLD: begin
            if (r_step != w_last) begin
               w_state_nxt = S_SETUP;
               w_step_nxt  = r_step + 3'd1;
               w_cnt_nxt   = CNT_W'(T_SU - 1);
            end else if (w_polled) begin
               w_state_nxt = S_POLL_RD;
               w_cnt_nxt   = CNT_W'(T_RD - 1);
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_POLL_RD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_POLL_GAP;
               w_dq7_nxt   = bus.sst_dq_i[7];
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_POLL_GAP: begin
            if (r_dq7 == w_pass_val) begin
               w_state_nxt = S_DONE;
            end else if (r_poll + 21'd1 == w_tmo) begin
               w_state_nxt = S_DONE;
               w_tmo_err   = 1'b1;
            end else begin
               w_state_nxt = S_POLL_RD;
               w_poll_nxt  = r_poll + 21'd1;
               w_cnt_nxt   = CNT_W'(T_RD - 1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pin values are derived from the next state so every output leaves a flop
   always_comb begin
      w_word  = seq_word(r_op, w_step_nxt, r_addr, r_data);
      w_ce_n  = 1'b1;
      w_oe_n  = 1'b1;
      w_we_n  = 1'b1;
      w_dq_oe = 1'b0;
      w_gnt   = 1'b0;
      w_addr  = r_sst_addr;
      w_dq_o  = r_dq_o;
      case (w_state_nxt)
         S_PI: begin
            w_gnt  = 1'b1;
            w_ce_n = bus.pi_ce_n;
            w_oe_n = bus.pi_oe_n;
            w_we_n = bus.pi_we_n;
            w_addr = bus.pi_addr;
         end
         S_SETUP, S_WPULSE, S_HOLD: begin
            w_ce_n  = (w_state_nxt == S_HOLD);
            w_we_n  = (w_state_nxt != S_WPULSE);
            w_dq_oe = 1'b1;
            w_addr  = w_word[ADDR_W+7:8];
            w_dq_o  = w_word[7:0];
         end
         S_POLL_RD: begin
            w_ce_n = 1'b0;
            w_oe_n = 1'b0;
            w_addr = r_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (cold_reset) begin
         r_state    <= S_IDLE;
         r_step     <= '0;
         r_cnt      <= '0;
         r_poll     <= '0;
         r_dq7      <= 1'b0;
         r_pending  <= 1'b0;
         r_bad      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_op       <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_sst_addr <= '0;
         r_dq_o     <= '0;
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_dq_oe    <= 1'b0;
         r_gnt      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_step     <= w_step_nxt;
         r_cnt      <= w_cnt_nxt;
         r_poll     <= w_poll_nxt;
         r_dq7      <= w_dq7_nxt;
         r_sst_addr <= w_addr;
         r_dq_o     <= w_dq_o;
         r_ce_n     <= w_ce_n;
         r_oe_n     <= w_oe_n;
         r_we_n     <= w_we_n;
         r_dq_oe    <= w_dq_oe;
         r_gnt      <= w_gnt;
         // A rejected op finishes on its own one clock later, without touching the FSM
         r_done     <= w_enter_done || r_bad;
         r_bad      <= 1'b0;
         if (w_enter_done || r_bad) r_busy <= 1'b0;
         if (w_tmo_err) r_err <= 1'b1;
         if (r_state == S_IDLE && w_state_nxt == S_SETUP) r_pending <= 1'b0;
         if (w_accept) begin
            r_busy <= 1'b1;
            if (w_bad_op) begin
               r_err <= 1'b1;
               r_bad <= 1'b1;
            end else begin
               r_err     <= 1'b0;
               r_pending <= 1'b1;
               r_op      <= bus.cmd_op;
               r_addr    <= bus.cmd_addr;
               r_data    <= bus.cmd_data;
            end
         end
      end
   end

   assign bus.pi_gnt    = r_gnt;
   assign bus.cmd_busy  = r_busy;
   assign bus.cmd_done  = r_done;
   assign bus.cmd_err   = r_err;
   assign bus.sst_addr  = r_sst_addr;
   assign bus.sst_ce_n  = r_ce_n;
   assign bus.sst_oe_n  = r_oe_n;
   assign bus.sst_we_n  = r_we_n;
   assign bus.sst_dq_o  = r_dq_o;
   assign bus.sst_dq_oe = r_dq_oe;
endmodule

// File: tb/tb_sst_flash_sequencer.sv
// Bench for sst_flash_sequencer: scoreboard of expected WE# bus writes plus a data#-polling flash model.
`timescale 1ns/1ps
module tb_sst_flash_sequencer;
   localparam int AW = 19;
   localparam int T_WP = 4;
   localparam int T_RD = 3;

   logic clk = 1'b0;
   logic cold_reset;
   always #5 clk = ~clk;

   sst_flash_sequencer_if #(.ADDR_W(AW)) bus();

   sst_flash_sequencer #(
      .ADDR_W(AW), .T_SU(2), .T_WP(T_WP), .T_RD(T_RD), .TMO_PROG(2048), .TMO_ERASE(8)
   ) dut (
      .clk(clk),
      .cold_reset(cold_reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW+7:0] sb[$];
   int cyc = 0;
   int we_falls = 0, polls = 0, we_len = 0, rd_len = 0, first_rd_cyc = -1;
   int busy_polls = 0;
   logic [7:0] busy_val = 8'h00, final_val = 8'h00;
   logic [AW-1:0] poll_addr = '0;
   bit chk_width = 1'b1;
   logic prev_we = 1'b1, prev_oe = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: scoreboard check on each WE# fall, pulse widths, poll reads and the flash DQ model
   always @(negedge clk) begin
      logic [AW+7:0] exp_w;
      logic rd;
      if (bus.sst_we_n === 1'b0 && bus.pi_gnt !== 1'b1) begin
         if (prev_we) begin
            we_falls++;
            we_len = 0;
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL sb_underflow: write addr=%h data=%h, none expected", bus.sst_addr, bus.sst_dq_o);
            end else begin
               exp_w = sb.pop_front();
               if ({bus.sst_addr, bus.sst_dq_o} !== exp_w || bus.sst_ce_n !== 1'b0 || bus.sst_dq_oe !== 1'b1) begin
                  n_bad++;
                  $display("FAIL sb_write: got addr=%h data=%h ce_n=%b dq_oe=%b, want addr=%h data=%h ce_n=0 dq_oe=1",
                           bus.sst_addr, bus.sst_dq_o, bus.sst_ce_n, bus.sst_dq_oe, exp_w[AW+7:8], exp_w[7:0]);
               end
            end
         end
         we_len++;
      end else if (!prev_we && chk_width) begin
         n_cmp++;
         if (we_len !== T_WP) begin
            n_bad++;
            $display("FAIL we_width: got %0d clocks, want %0d", we_len, T_WP);
         end
      end
      prev_we = bus.sst_we_n | bus.pi_gnt;

      rd = (bus.sst_ce_n === 1'b0 && bus.sst_oe_n === 1'b0 && bus.pi_gnt !== 1'b1);
      if (rd) begin
         if (prev_oe) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_len = 0;
            n_cmp++;
            if (bus.sst_addr !== poll_addr || bus.sst_dq_oe !== 1'b0) begin
               n_bad++;
               $display("FAIL poll_pins: got addr=%h dq_oe=%b, want addr=%h dq_oe=0", bus.sst_addr, bus.sst_dq_oe, poll_addr);
            end
         end
         rd_len++;
         bus.sst_dq_i = (polls < busy_polls) ? busy_val : final_val;
      end else if (!prev_oe) begin
         polls++;
         if (chk_width) begin
            n_cmp++;
            if (rd_len !== T_RD) begin
               n_bad++;
               $display("FAIL rd_width: got %0d clocks, want %0d", rd_len, T_RD);
            end
         end
      end
      prev_oe = !rd;
   end

   task automatic clr_stats();
      we_falls = 0;
      polls = 0;
      first_rd_cyc = -1;
   endtask

   task automatic pulse_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_start = 1'b1;
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit to);
      to = 1'b1;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (bus.cmd_done === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic push_prefix();
      sb.push_back({19'h05555, 8'hAA});
      sb.push_back({19'h02AAA, 8'h55});
   endtask

   task automatic test_reset();
      cold_reset = 1'b1;
      bus.pi_req = 1'b0; bus.pi_addr = '0; bus.pi_ce_n = 1'b1; bus.pi_oe_n = 1'b1; bus.pi_we_n = 1'b1;
      bus.cmd_start = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0; bus.sst_dq_i = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.sst_ce_n, bus.sst_oe_n, bus.sst_we_n, bus.sst_dq_oe, bus.pi_gnt, bus.cmd_busy, bus.cmd_done, bus.cmd_err} !== 8'b1110_0000
          || bus.sst_addr !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got ce/oe/we/dqoe/gnt/busy/done/err=%b%b%b%b%b%b%b%b addr=%h, want 11100000 addr=0",
                  bus.sst_ce_n, bus.sst_oe_n, bus.sst_we_n, bus.sst_dq_oe, bus.pi_gnt, bus.cmd_busy, bus.cmd_done, bus.cmd_err, bus.sst_addr);
      end
      cold_reset = 1'b0;
   endtask

   task automatic test_prog();
      bit to;
      int t0;
      clr_stats();
      busy_polls = 2; busy_val = 8'h80; final_val = 8'h5A; poll_addr = 19'h01234;
      push_prefix();
      sb.push_back({19'h05555, 8'hA0});
      sb.push_back({19'h01234, 8'h5A});
      pulse_cmd(3'd0, 19'h01234, 8'h5A);
      t0 = cyc;
      wait_done(400, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL prog_done: got timeout, want cmd_done"); end
      n_cmp++; if (we_falls !== 4) begin n_bad++; $display("FAIL prog_pulses: got %0d want 4", we_falls); end
      n_cmp++; if (polls !== 3) begin n_bad++; $display("FAIL prog_polls: got %0d want 3", polls); end
      n_cmp++; if (first_rd_cyc - t0 !== 29) begin n_bad++; $display("FAIL prog_latency: got %0d want 29", first_rd_cyc - t0); end
      n_cmp++;
      if (bus.cmd_err !== 1'b0 || bus.cmd_busy !== 1'b0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL prog_end: got err=%b busy=%b left=%0d, want 0 0 0", bus.cmd_err, bus.cmd_busy, sb.size());
      end
   endtask

   task automatic test_erase_timeout();
      bit to;
      clr_stats();
      busy_polls = 1000; busy_val = 8'h00; final_val = 8'h00; poll_addr = 19'h02000;
      push_prefix();
      sb.push_back({19'h05555, 8'h80});
      push_prefix();
      sb.push_back({19'h02000, 8'h30});
      pulse_cmd(3'd1, 19'h02000, 8'h00);
      wait_done(600, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL erase_done: got timeout, want cmd_done"); end
      n_cmp++; if (we_falls !== 6) begin n_bad++; $display("FAIL erase_pulses: got %0d want 6", we_falls); end
      n_cmp++; if (polls !== 8) begin n_bad++; $display("FAIL erase_polls: got %0d want 8", polls); end
      n_cmp++;
      if (bus.cmd_err !== 1'b1 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL erase_err: got err=%b left=%0d, want err=1 left=0", bus.cmd_err, sb.size());
      end
   endtask

   task automatic test_pi_arb();
      bit to;
      logic [AW-1:0] a;
      clr_stats();
      busy_polls = 0; final_val = 8'h3C; poll_addr = 19'h00456;
      push_prefix();
      sb.push_back({19'h05555, 8'hA0});
      sb.push_back({19'h00456, 8'h3C});
      @(posedge clk); #1;
      bus.pi_req = 1'b1; bus.pi_ce_n = 1'b0; bus.pi_oe_n = 1'b0; bus.pi_addr = 19'h11111;
      bus.cmd_op = 3'd0; bus.cmd_addr = 19'h00456; bus.cmd_data = 8'h3C; bus.cmd_start = 1'b1;
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
      n_cmp++;
      if (bus.pi_gnt !== 1'b1 || bus.cmd_busy !== 1'b1 || bus.sst_addr !== 19'h11111 || bus.sst_oe_n !== 1'b0) begin
         n_bad++;
         $display("FAIL pi_grant: got gnt=%b busy=%b addr=%h oe_n=%b, want 1 1 11111 0", bus.pi_gnt, bus.cmd_busy, bus.sst_addr, bus.sst_oe_n);
      end
      for (int i = 0; i < 6; i++) begin
         a = AW'($urandom);
         bus.pi_addr = a;
         bus.pi_oe_n = i[0];
         @(posedge clk); #1;
         n_cmp++;
         if (bus.sst_addr !== a || bus.sst_oe_n !== i[0] || bus.pi_gnt !== 1'b1 || bus.sst_dq_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL pi_track: got addr=%h oe_n=%b gnt=%b dq_oe=%b, want addr=%h oe_n=%b gnt=1 dq_oe=0",
                     bus.sst_addr, bus.sst_oe_n, bus.pi_gnt, bus.sst_dq_oe, a, i[0]);
         end
      end
      n_cmp++; if (we_falls !== 0) begin n_bad++; $display("FAIL pi_no_we: got %0d WE# pulses, want 0", we_falls); end
      bus.pi_req = 1'b0; bus.pi_ce_n = 1'b1; bus.pi_oe_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.pi_gnt !== 1'b0 || bus.sst_ce_n !== 1'b1 || bus.sst_oe_n !== 1'b1 || bus.sst_we_n !== 1'b1) begin
         n_bad++;
         $display("FAIL pi_release: got gnt=%b ce/oe/we=%b%b%b, want 0 111", bus.pi_gnt, bus.sst_ce_n, bus.sst_oe_n, bus.sst_we_n);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.sst_ce_n !== 1'b0 || bus.sst_dq_oe !== 1'b1 || bus.sst_addr !== 19'h05555) begin
         n_bad++;
         $display("FAIL pi_seq_start: got ce_n=%b dq_oe=%b addr=%h, want 0 1 05555", bus.sst_ce_n, bus.sst_dq_oe, bus.sst_addr);
      end
      wait_done(400, to);
      n_cmp++;
      if (to !== 1'b0 || we_falls !== 4 || polls !== 1 || bus.cmd_err !== 1'b0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL pi_cmd_end: got to=%b pulses=%0d polls=%0d err=%b left=%0d, want 0 4 1 0 0",
                  to, we_falls, polls, bus.cmd_err, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      clr_stats();
      busy_polls = 0; final_val = 8'h11; poll_addr = 19'h00777;
      push_prefix();
      sb.push_back({19'h05555, 8'hA0});
      sb.push_back({19'h00777, 8'h11});
      pulse_cmd(3'd0, 19'h00777, 8'h11);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (we_falls >= 3) begin seen = 1'b1; break; end
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach: got %0d pulses, want 3", we_falls); end
      chk_width = 1'b0;
      cold_reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.sst_we_n !== 1'b1 || bus.sst_ce_n !== 1'b1 || bus.sst_oe_n !== 1'b1 || bus.sst_dq_oe !== 1'b0 || bus.cmd_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_pins: got we/ce/oe=%b%b%b dq_oe=%b busy=%b, want 111 0 0",
                  bus.sst_we_n, bus.sst_ce_n, bus.sst_oe_n, bus.sst_dq_oe, bus.cmd_busy);
      end
      cold_reset = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      n_cmp++;
      if (we_falls !== 3 || bus.cmd_busy !== 1'b0 || bus.cmd_err !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b err=%b, want 3 0 0", we_falls, bus.cmd_busy, bus.cmd_err);
      end
      sb.delete();
      chk_width = 1'b1;
   endtask

   task automatic test_bad_op();
      bit to;
      clr_stats();
      pulse_cmd(3'd6, 19'h00100, 8'hC3);
      n_cmp++;
      if (bus.cmd_err !== 1'b1 || bus.cmd_done !== 1'b0 || bus.cmd_busy !== 1'b1 || bus.sst_ce_n !== 1'b1) begin
         n_bad++;
         $display("FAIL bad_accept: got err=%b done=%b busy=%b ce_n=%b, want 1 0 1 1", bus.cmd_err, bus.cmd_done, bus.cmd_busy, bus.sst_ce_n);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.cmd_done !== 1'b1 || bus.cmd_busy !== 1'b0 || bus.cmd_err !== 1'b1 || bus.sst_ce_n !== 1'b1) begin
         n_bad++;
         $display("FAIL bad_done: got done=%b busy=%b err=%b ce_n=%b, want 1 0 1 1", bus.cmd_done, bus.cmd_busy, bus.cmd_err, bus.sst_ce_n);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.cmd_done !== 1'b0 || we_falls !== 0) begin
         n_bad++;
         $display("FAIL bad_after: got done=%b pulses=%0d, want 0 0", bus.cmd_done, we_falls);
      end
      busy_polls = 1; busy_val = 8'h00; final_val = 8'hC3; poll_addr = 19'h00100;
      push_prefix();
      sb.push_back({19'h05555, 8'hA0});
      sb.push_back({19'h00100, 8'hC3});
      pulse_cmd(3'd0, 19'h00100, 8'hC3);
      n_cmp++;
      if (bus.cmd_err !== 1'b0 || bus.cmd_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL bad_err_clear: got err=%b busy=%b, want 0 1", bus.cmd_err, bus.cmd_busy);
      end
      wait_done(400, to);
      n_cmp++;
      if (to !== 1'b0 || polls !== 2 || we_falls !== 4 || bus.cmd_err !== 1'b0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL bad_then_prog: got to=%b polls=%0d pulses=%0d err=%b left=%0d, want 0 2 4 0 0",
                  to, polls, we_falls, bus.cmd_err, sb.size());
      end
   endtask

   task automatic test_busy_ignore_id();
      bit to;
      clr_stats();
      push_prefix();
      sb.push_back({19'h05555, 8'h90});
      pulse_cmd(3'd3, 19'h00000, 8'h00);
      repeat (3) @(posedge clk);
      pulse_cmd(3'd0, 19'h7FFFF, 8'hFF);
      n_cmp++;
      if (bus.cmd_busy !== 1'b1 || bus.cmd_err !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_ignore: got busy=%b err=%b, want 1 0", bus.cmd_busy, bus.cmd_err);
      end
      wait_done(200, to);
      n_cmp++;
      if (to !== 1'b0 || we_falls !== 3 || polls !== 0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL id_entry: got to=%b pulses=%0d polls=%0d left=%0d, want 0 3 0 0", to, we_falls, polls, sb.size());
      end
      // Issue ID exit during the DONE cycle of ID entry
      clr_stats();
      sb.push_back({19'h05555, 8'hF0});
      bus.cmd_op = 3'd4; bus.cmd_addr = '0; bus.cmd_data = '0; bus.cmd_start = 1'b1;
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
      n_cmp++; if (bus.cmd_busy !== 1'b1) begin n_bad++; $display("FAIL done_cycle_accept: got busy=%b want 1", bus.cmd_busy); end
      wait_done(200, to);
      n_cmp++;
      if (to !== 1'b0 || we_falls !== 1 || polls !== 0 || sb.size() != 0) begin
         n_bad++;
         $display("FAIL id_exit: got to=%b pulses=%0d polls=%0d left=%0d, want 0 1 0 0", to, we_falls, polls, sb.size());
      end
      repeat (40) @(posedge clk);
      #1;
      n_cmp++;
      if (we_falls !== 1 || bus.cmd_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL id_quiet: got pulses=%0d busy=%b, want 1 0", we_falls, bus.cmd_busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_prog();
      test_erase_timeout();
      test_pi_arb();
      test_reset_mid();
      test_bad_op();
      test_busy_ignore_id();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
